// File: rtl/dallanma_cozucu.sv
// Execute-stage branch/jump resolver: computes taken/target/link, strobes the predictor and
// turns a mispredict verdict into a one-cycle front-end redirect followed by a wrong-path shadow.
module dallanma_cozucu #(
  parameter int GOLGE_CEVRIM = 1,
  parameter int SAYAC_BIT    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ddb_durdur_i,
  input  logic                 dal_i,
  input  logic                 jal_i,
  input  logic                 jalr_i,
  input  logic [2:0]           kosul_i,
  input  logic                 ctipi_i,
  input  logic [30:0]          ps_i,
  input  logic [31:0]          rs1_i,
  input  logic [31:0]          rs2_i,
  input  logic [31:0]          anlik_i,
  input  logic [1:0]           hata_duzelt_i,
  output logic [30:0]          atlanan_ps_o,
  output logic                 atlanan_ps_gecerli_o,
  output logic                 tahmin_et_o,
  output logic [31:0]          donus_deger_o,
  output logic                 yonlendir_o,
  output logic [30:0]          yonlendir_ps_o,
  output logic [SAYAC_BIT-1:0] dallanma_sayisi_o,
  output logic [SAYAC_BIT-1:0] hata_sayisi_o
);

  typedef enum logic [1:0] {
    SORUN_YOK     = 2'b00,
    ATLAMAMALIYDI = 2'b01,
    ATLAMALIYDI   = 2'b10,
    YANLIS_ATLADI = 2'b11
  } hata_e;

  typedef enum logic [1:0] {
    BOS,
    YONLENDIR,
    GOLGE
  } durum_e;

  // The shadow counter only ever holds GOLGE_CEVRIM-1 down to 0.
  localparam int GW = (GOLGE_CEVRIM > 1) ? $clog2(GOLGE_CEVRIM) : 1;
  localparam logic [GW-1:0] GOLGE_BAS = GW'((GOLGE_CEVRIM > 0) ? GOLGE_CEVRIM - 1 : 0);
  localparam logic [GW-1:0] GOLGE_BIR = GW'(1);
  localparam logic [SAYAC_BIT-1:0] SAYAC_BIR = SAYAC_BIT'(1);

  durum_e      durum;
  logic [GW-1:0] golge_sayac;

  logic        kontrol;
  logic        kosul_saglandi;
  logic        atla;
  logic        jalr_tasima;
  logic        yanlis_tahmin;
  logic [30:0] dal_hedef;
  logic [30:0] jalr_hedef;
  logic [30:0] hedef_ps;
  logic [30:0] sirali_ps;

  always_comb begin
    case (kosul_i)
      3'b000:  kosul_saglandi = (rs1_i == rs2_i);
      3'b001:  kosul_saglandi = (rs1_i != rs2_i);
      3'b100:  kosul_saglandi = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  kosul_saglandi = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  kosul_saglandi = (rs1_i <  rs2_i);
      3'b111:  kosul_saglandi = (rs1_i >= rs2_i);
      default: kosul_saglandi = 1'b0;
    endcase
  end

  // Targets are formed directly on halfword addresses; the PC's bit 0 is always zero, so only
  // JALR can carry out of bit 0 into bit 1.
  assign jalr_tasima = rs1_i[0] & anlik_i[0];
  assign dal_hedef   = ps_i + anlik_i[31:1];
  assign jalr_hedef  = rs1_i[31:1] + anlik_i[31:1] + {30'd0, jalr_tasima};
  assign hedef_ps    = jalr_i ? jalr_hedef : dal_hedef;
  assign sirali_ps   = ps_i + (ctipi_i ? 31'd1 : 31'd2);

  assign kontrol              = dal_i | jal_i | jalr_i;
  assign atla                 = jal_i | jalr_i | (dal_i & kosul_saglandi);
  assign atlanan_ps_o         = atla ? hedef_ps : sirali_ps;
  assign atlanan_ps_gecerli_o = atla;
  assign donus_deger_o        = {sirali_ps, 1'b0};
  assign tahmin_et_o          = kontrol & (durum == BOS);
  assign yanlis_tahmin        = tahmin_et_o & (hata_duzelt_i != SORUN_YOK);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum             <= BOS;
      golge_sayac       <= '0;
      yonlendir_o       <= 1'b0;
      yonlendir_ps_o    <= '0;
      dallanma_sayisi_o <= '0;
      hata_sayisi_o     <= '0;
    end else if (!ddb_durdur_i) begin
      if (tahmin_et_o && (dallanma_sayisi_o != '1))
        dallanma_sayisi_o <= dallanma_sayisi_o + SAYAC_BIR;
      case (durum)
        BOS: begin
          if (yanlis_tahmin) begin
            durum          <= YONLENDIR;
            yonlendir_o    <= 1'b1;
            yonlendir_ps_o <= (hata_duzelt_i == ATLAMAMALIYDI) ? sirali_ps : hedef_ps;
            if (hata_sayisi_o != '1)
              hata_sayisi_o <= hata_sayisi_o + SAYAC_BIR;
          end
        end
        YONLENDIR: begin
          yonlendir_o <= 1'b0;
          if (GOLGE_CEVRIM == 0) begin
            durum <= BOS;
          end else begin
            durum       <= GOLGE;
            golge_sayac <= GOLGE_BAS;
          end
        end
        GOLGE: begin
          if (golge_sayac == '0)
            durum <= BOS;
          else
            golge_sayac <= golge_sayac - GOLGE_BIR;
        end
        default: durum <= BOS;
      endcase
    end
  end

endmodule
